// File: rtl/conv_post_sched_pkg.sv
// Shared widths, state encoding and helpers for the post-processing scheduler.
package conv_post_sched_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int BIAS_WIDTH  = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int MAX_OC      = 64;
  localparam int PIX_W       = 16;
  localparam int CREDITS     = 4;

  localparam int OC_AW   = $clog2(MAX_OC);
  localparam int OC_NW   = OC_AW + 1;
  localparam int CRED_W  = $clog2(CREDITS + 1);
  localparam int OUTST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Channel counts above the bank depth run as a full bank.
  function automatic logic [OC_NW-1:0] clamp_oc(input logic [OC_NW-1:0] n);
    if (n > OC_NW'(MAX_OC)) return OC_NW'(MAX_OC);
    return n;
  endfunction

endpackage

// File: rtl/conv_post_sched_if.sv
// Accumulator input stream and post-stage issue/return signals.
interface conv_post_sched_if;
  import conv_post_sched_pkg::*;

  logic                   acc_valid;
  logic                   acc_ready;
  logic [DATA_WIDTH-1:0]  acc_sum;
  logic                   pp_valid_in;
  logic [DATA_WIDTH-1:0]  pp_sum;
  logic [BIAS_WIDTH-1:0]  pp_bias;
  logic [SCALE_WIDTH-1:0] pp_scale;
  logic                   pp_valid_out;
  logic                   credit_ret;

  modport master (
    output acc_valid, acc_sum, pp_valid_out, credit_ret,
    input  acc_ready, pp_valid_in, pp_sum, pp_bias, pp_scale
  );

  modport slave (
    input  acc_valid, acc_sum, pp_valid_out, credit_ret,
    output acc_ready, pp_valid_in, pp_sum, pp_bias, pp_scale
  );
endinterface

// File: rtl/conv_post_sched_param_bank.sv
// Per-channel bias/scale storage: one write port, combinational read, no reset.
module conv_post_sched_param_bank
  import conv_post_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [OC_AW-1:0]       waddr,
  input  logic [BIAS_WIDTH-1:0]  wbias,
  input  logic [SCALE_WIDTH-1:0] wscale,
  input  logic [OC_AW-1:0]       raddr,
  output logic [BIAS_WIDTH-1:0]  rd_bias,
  output logic [SCALE_WIDTH-1:0] rd_scale
);

  logic [BIAS_WIDTH-1:0]  bias_mem  [MAX_OC];
  logic [SCALE_WIDTH-1:0] scale_mem [MAX_OC];

  // Write port; contents survive reset so a layer can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (we) begin
      bias_mem[waddr]  <= wbias;
      scale_mem[waddr] <= wscale;
    end
  end

  assign rd_bias  = bias_mem[raddr];
  assign rd_scale = scale_mem[raddr];

endmodule

// File: rtl/conv_post_sched.sv
// Post-processing scheduler: pairs each accumulator sum with its channel's
// bias/scale and issues it to the post stage under downstream credit control.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | waiting for cfg_start; parameter bank writable
//  ST_RUN   | accepting sums while credits remain, one issue per cycle
//  ST_DRAIN | all sums issued; waiting for post-stage results to return
module conv_post_sched
  import conv_post_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [OC_NW-1:0]       cfg_oc_num,
  input  logic [PIX_W-1:0]       cfg_pix_num,
  output logic                   busy,
  output logic                   done,
  input  logic                   prm_we,
  input  logic [OC_AW-1:0]       prm_addr,
  input  logic [BIAS_WIDTH-1:0]  prm_bias,
  input  logic [SCALE_WIDTH-1:0] prm_scale,
  conv_post_sched_if.slave       bus
);

  state_e                 state_q, state_d;
  logic [OC_NW-1:0]       oc_num_q, oc_num_d;
  logic [PIX_W-1:0]       pix_num_q, pix_num_d;
  logic [OC_AW-1:0]       oc_cnt_q, oc_cnt_d;
  logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [CRED_W-1:0]      credits_q, credits_d;
  logic [OUTST_W-1:0]     outst_q, outst_d;
  logic                   done_q, done_d;
  logic                   pp_valid_q, pp_valid_d;
  logic [DATA_WIDTH-1:0]  pp_sum_q, pp_sum_d;
  logic [BIAS_WIDTH-1:0]  pp_bias_q, pp_bias_d;
  logic [SCALE_WIDTH-1:0] pp_scale_q, pp_scale_d;

  logic                   acc_ready_c;
  logic                   issue;
  logic                   drain_exit;
  logic [BIAS_WIDTH-1:0]  rd_bias;
  logic [SCALE_WIDTH-1:0] rd_scale;

  conv_post_sched_param_bank u_bank (
    .clk      (clk),
    .we       (prm_we && (state_q == ST_IDLE)),
    .waddr    (prm_addr),
    .wbias    (prm_bias),
    .wscale   (prm_scale),
    .raddr    (oc_cnt_q),
    .rd_bias  (rd_bias),
    .rd_scale (rd_scale)
  );

  assign acc_ready_c = (state_q == ST_RUN) && (credits_q != '0);
  assign issue       = acc_ready_c && bus.acc_valid;
  assign drain_exit  = (state_q == ST_DRAIN) && (outst_q == '0) && !pp_valid_q;

  // Next-state, layer counters, credit/outstanding tracking and issue register.
  always_comb begin
    state_d    = state_q;
    oc_num_d   = oc_num_q;
    pix_num_d  = pix_num_q;
    oc_cnt_d   = oc_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    credits_d  = credits_q;
    outst_d    = outst_q;
    done_d     = 1'b0;
    pp_valid_d = issue;
    pp_sum_d   = pp_sum_q;
    pp_bias_d  = pp_bias_q;
    pp_scale_d = pp_scale_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          // An empty layer completes immediately without ever going busy.
          if ((cfg_oc_num == '0) || (cfg_pix_num == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
            oc_num_d  = clamp_oc(cfg_oc_num);
            pix_num_d = cfg_pix_num;
            oc_cnt_d  = '0;
            pix_cnt_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          if ({1'b0, oc_cnt_q} == oc_num_q - OC_NW'(1)) begin
            oc_cnt_d = '0;
            if (pix_cnt_q == pix_num_q - PIX_W'(1)) begin
              state_d = ST_DRAIN;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end else begin
            oc_cnt_d = oc_cnt_q + OC_AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case ({issue, bus.credit_ret})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   if (credits_q < CRED_W'(CREDITS)) credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase

    case ({pp_valid_q, bus.pp_valid_out})
      2'b10:   outst_d = outst_q + OUTST_W'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - OUTST_W'(1);
      default: outst_d = outst_q;
    endcase

    if (issue) begin
      pp_sum_d   = bus.acc_sum;
      pp_bias_d  = rd_bias;
      pp_scale_d = rd_scale;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      oc_num_q   <= '0;
      pix_num_q  <= '0;
      oc_cnt_q   <= '0;
      pix_cnt_q  <= '0;
      credits_q  <= CRED_W'(CREDITS);
      outst_q    <= '0;
      done_q     <= 1'b0;
      pp_valid_q <= 1'b0;
      pp_sum_q   <= '0;
      pp_bias_q  <= '0;
      pp_scale_q <= '0;
    end else begin
      state_q    <= state_d;
      oc_num_q   <= oc_num_d;
      pix_num_q  <= pix_num_d;
      oc_cnt_q   <= oc_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      credits_q  <= credits_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      pp_valid_q <= pp_valid_d;
      pp_sum_q   <= pp_sum_d;
      pp_bias_q  <= pp_bias_d;
      pp_scale_q <= pp_scale_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q || drain_exit;
  assign bus.acc_ready   = acc_ready_c;
  assign bus.pp_valid_in = pp_valid_q;
  assign bus.pp_sum      = pp_sum_q;
  assign bus.pp_bias     = pp_bias_q;
  assign bus.pp_scale    = pp_scale_q;

endmodule
